// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
// Imported by the interface, controller and storage.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RLAT,
    RBURST
  } state_e;

  localparam int MEM_LEN_WIDTH = 8;
  localparam int WORD_BYTES    = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between a cache controller
// memory port (master) and the responder (slave).
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_SIZE_BYTES = 4
);

  logic                       i_req;
  logic [ADDR_WIDTH-1:0]      i_addr;
  logic                       i_wen;
  logic [DATA_SIZE_BYTES-1:0] i_ben;
  logic [MEM_LEN_WIDTH-1:0]   i_len;
  logic [DATA_WIDTH-1:0]      i_data;
  logic                       o_rdy;
  logic                       o_valid;
  logic [DATA_WIDTH-1:0]      o_data;

  modport master (
    output i_req, i_addr, i_wen,
    output i_ben, i_len, i_data,
    input  o_rdy, o_valid, o_data
  );

  modport slave (
    input  i_req, i_addr, i_wen,
    input  i_ben, i_len, i_data,
    output o_rdy, o_valid, o_data
  );

endinterface

// File: rtl/mem_responder_ram.sv
// Single-port word RAM, byte-enabled write, registered read.
// Contents are deliberately not reset.
module mem_responder_ram #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int NB = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [NB-1:0] ben_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (ben_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: single-beat byte-masked writes and
// fixed-latency wrapping read bursts over a word RAM.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_SIZE_BYTES = 4,
  parameter int READ_LATENCY    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_responder_if.slave  bus
);

  localparam int OFS   = $clog2(WORD_BYTES);
  localparam int WA    = ADDR_WIDTH - OFS;
  localparam int LAT_W = 8;
  localparam logic [LAT_W-1:0] LAT_LAST =
    LAT_W'(READ_LATENCY - 1);

  state_e                     state_q, state_d;
  logic [WA-1:0]              ptr_q, ptr_d;
  logic [DATA_SIZE_BYTES-1:0] ben_q, ben_d;
  logic [MEM_LEN_WIDTH-1:0]   len_q, len_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [8:0]                 beat_q, beat_d;
  logic [LAT_W-1:0]           lat_q, lat_d;
  logic                       ram_we;
  logic [DATA_WIDTH-1:0]      ram_rdata;
  logic                       unused_ofs;

  assign unused_ofs = ^bus.i_addr[OFS-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ben_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ben_q   <= ben_d;
      len_q   <= len_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
    end
  end

  // ptr_q runs one word ahead of the beat on the bus
  // to cover the registered RAM read.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ben_d   = ben_q;
    len_d   = len_q;
    data_d  = data_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    ram_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req) begin
          ptr_d   = bus.i_addr[ADDR_WIDTH-1:OFS];
          ben_d   = bus.i_ben;
          len_d   = bus.i_len;
          data_d  = bus.i_data;
          beat_d  = '0;
          lat_d   = '0;
          state_d = bus.i_wen ? WRITE : RLAT;
        end
      end
      WRITE: begin
        ram_we  = 1'b1;
        state_d = IDLE;
      end
      RLAT: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          ptr_d   = ptr_q + WA'(1);
          state_d = RBURST;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      RBURST: begin
        ptr_d = ptr_q + WA'(1);
        if (beat_q == {1'b0, len_q}) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  mem_responder_ram #(
    .AW (WA),
    .DW (DATA_WIDTH),
    .NB (DATA_SIZE_BYTES)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ptr_q),
    .ben_i   (ben_q),
    .wdata_i (data_q),
    .rdata_o (ram_rdata)
  );

  assign bus.o_rdy   = (state_q == IDLE);
  assign bus.o_valid = (state_q == RBURST);
  assign bus.o_data  = bus.o_valid ? ram_rdata : '0;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters, each SHALL be name, default, meaning:
  ADDR_WIDTH, 10, byte address width.
  DATA_WIDTH, 32, beat width in bits.
  DATA_SIZE_BYTES, 4, byte lanes per beat.
  READ_LATENCY, 2, idle cycles between request accept and first read beat (minimum 1).
REQ-002 Ports SHALL be name, direction, width, meaning:
  clk  in  1  single clock, rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  i_req  in  1  request from cache controller memory port.
  i_addr  in  ADDR_WIDTH  byte address of first beat.
  i_wen  in  1  1 = write, 0 = read.
  i_ben  in  DATA_SIZE_BYTES  write byte enables.
  i_len  in  8  read burst length; beats = i_len+1; ignored for writes.
  i_data  in  DATA_WIDTH  write data.
  o_rdy  out  1  responder idle and able to accept.
  o_valid  out  1  read beat valid.
  o_data  out  DATA_WIDTH  read beat data.

Function
REQ-003 Request SHALL be accepted on a rising clk edge where i_req && o_rdy; addr, wen, ben, len and data SHALL be captured at that edge.
REQ-004 o_rdy SHALL be low from the cycle after accept until the transaction completes; i_req while o_rdy is low SHALL be ignored.
REQ-005 State machine SHALL have states IDLE, WRITE, RLAT, RBURST; o_rdy = 1 only in IDLE.
REQ-006 IDLE -> WRITE on accepted write; IDLE -> RLAT on accepted read.
REQ-007 WRITE SHALL last exactly one cycle and update only the enabled bytes of the word at captured address; it SHALL then return to IDLE, so o_rdy is high 2 cycles after accept.
REQ-008 RLAT SHALL last READ_LATENCY cycles, then go to RBURST.
REQ-009 RBURST SHALL assert o_valid for exactly i_len+1 consecutive cycles, one beat per cycle, with no gaps.
REQ-010 Beat k SHALL return the word at (captured addr + 4*k) modulo 2^ADDR_WIDTH; wrap past the top address SHALL go to 0.
REQ-011 The cycle after the last beat SHALL be IDLE with o_rdy = 1 and o_valid = 0.
REQ-012 o_data SHALL be 0 whenever o_valid = 0.
REQ-013 Address bits [1:0] SHALL be ignored, and all accesses treated as word-aligned.
REQ-014 A write with i_ben = 0 SHALL complete normally without modifying storage.
REQ-015 Back-to-back: a request presented in the first cycle o_rdy is high SHALL be accepted at that edge.
REQ-016 Read-after-write to the same word SHALL return the written data (write completes before o_rdy rises).
REQ-017 Beat counter SHALL be 9 bits, so i_len = 255 yields exactly 256 beats.

Reset
REQ-018 Assertion of reset_n low SHALL immediately force: state IDLE, o_rdy = 1, o_valid = 0, o_data = 0, beat counter 0, and latency counter 0.
REQ-019 Reset mid-burst SHALL abort the burst with no further beats after reset deasserts, and mid-write SHALL leave the word either fully old or fully new.
REQ-020 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-021 A shared package SHALL hold the state enum (IDLE, WRITE, RLAT, RBURST), MEM_LEN_WIDTH = 8, and WORD_BYTES = 4.
REQ-022 Storage SHALL be one sub-module, mem_responder_ram: single-port, 2^(ADDR_WIDTH-2) words, byte-enabled synchronous write, read data registered one cycle; the controller SHALL issue the read address one cycle ahead of each beat.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  Write 0x040 data 0xDEADBEEF ben 0xF, then read 0x040 len 0 -> o_rdy high 2 cycles after write accept; single beat 0xDEADBEEF arrives READ_LATENCY+1 cycles after read accept.
  Write words 0x100..0x10C = 1,2,3,4, then read 0x100 len 3 -> 4 consecutive beats 1,2,3,4; o_rdy high the cycle after beat 4.
  Word 0x080 = 0x11223344, write 0xAABBCCDD with ben 0x5 -> read returns 0x11BB33DD.
  Read 0x3F8 len 3 -> beats from 0x3F8, 0x3FC, 0x000, 0x004.
  Reset asserted on the second of 4 beats -> o_valid drops immediately, no beats after release, o_rdy = 1.
  i_req held with new address while busy, then held through the o_rdy rise -> only the request at the rise edge is accepted; the busy-time request produces no response.
